// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Instruction-fetch controller placed between a small instruction memory and
// the simple_processor datapath. It owns the program counter, which also
// serves as the memory address. Each instruction word is captured into the
// instruction register once the memory read latency has elapsed. The word is
// then handed to the datapath with a run/done handshake.
//
// Handshake: run is a one-cycle pulse meaning "ir holds a fresh instruction".
// The datapath answers with done, which may come in any EXEC cycle,
// including the run cycle itself. Each done retires exactly one instruction.
// done and pc_load are ignored outside EXEC.
//
// Ports
//   clk_addr   in   clock, every register updates on the rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin/restart fetching (sampled in IDLE and HALT only)
//   DIN        in   instruction memory read data, valid MEM_LAT cycles
//                   after addr changes
//   done       in   datapath finished the current instruction
//   pc_load    in   redirect the PC to pc_in when done is accepted
//   pc_in      in   redirect target
//   addr       out  memory address (the PC register itself)
//   ir         out  instruction register
//   run        out  one-cycle pulse, ir valid
//   halted     out  high while stopped on HALT_WORD
//   instr_cnt  out  retired-instruction count, saturating at 255
//   dbg_state  out  current FSM state, for observation only
module fetch_sequencer #(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 16,
  parameter int                 MEM_LAT   = 1,
  parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF
) (
  input  logic              clk_addr,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] DIN,
  input  logic              done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] ir,
  output logic              run,
  output logic              halted,
  output logic [7:0]        instr_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // The wait counter has to reach MEM_LAT, so it needs enough bits for that value.
  localparam int              CNT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_wait;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_run;
  logic              r_halted;
  logic [7:0]        r_cnt;

  logic w_fetch_last;
  logic w_is_halt;

  assign w_fetch_last = (r_wait == LAST_CNT);
  assign w_is_halt    = (DIN == HALT_WORD);

  always_ff @(posedge clk_addr) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_run    <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // run is a pulse: it drops unless the final FETCH cycle raises it again.
      r_run <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        S_FETCH: begin
          if (w_fetch_last) begin
            // Advance the PC here, so a redirect to the word just fetched
            // (a tight loop) works through the normal pc_load path.
            r_ir   <= DIN;
            r_pc   <= r_pc + ADDR_W'(1);
            r_wait <= '0;
            if (w_is_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_EXEC;
              r_run   <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (done) begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (pc_load) r_pc <= pc_in;
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        S_HALT: begin
          if (start) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
            r_wait   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr      = r_pc;
  assign ir        = r_ir;
  assign run       = r_run;
  assign halted    = r_halted;
  assign instr_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HALT = 2'd3;

  logic        clk_addr = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [15:0] DIN;
  logic        done     = 1'b0;
  logic        pc_load  = 1'b0;
  logic [4:0]  pc_in    = 5'd0;
  logic [4:0]  addr;
  logic [15:0] ir;
  logic        run;
  logic        halted;
  logic [7:0]  instr_cnt;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mem [32];

  fetch_sequencer #(
    .ADDR_W(5), .DATA_W(16), .MEM_LAT(1), .HALT_WORD(16'hFFFF)
  ) dut (
    .clk_addr (clk_addr),
    .reset    (reset),
    .start    (start),
    .DIN      (DIN),
    .done     (done),
    .pc_load  (pc_load),
    .pc_in    (pc_in),
    .addr     (addr),
    .ir       (ir),
    .run      (run),
    .halted   (halted),
    .instr_cnt(instr_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk_addr = ~clk_addr;
  always @(posedge clk_addr) cyc <= cyc + 1;

  // instruction memory with a one-cycle registered read
  always @(posedge clk_addr) DIN <= mem[addr];

  task automatic tick();
    @(posedge clk_addr);
    #1;
  endtask

  // Bounded wait for the next run pulse. An expired bound counts as a failure.
  task automatic wait_run(output int at_cyc);
    bit seen;
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run === 1'b1) begin
        seen = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL run_timeout: got no run pulse within 20 cycles, required one");
    end
  endtask

  task automatic give_done(input logic load, input logic [4:0] tgt);
    done = 1'b1; pc_load = load; pc_in = tgt;
    tick();
    done = 1'b0; pc_load = 1'b0;
  endtask

  task automatic wait_halt();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL halt_timeout: halted stayed low for 20 cycles, required high");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = ~start; done = ~done;
      tick();
    end
    start = 1'b0; done = 1'b0;
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d, required 0", addr); end
    checks++; if (ir !== 16'h0) begin failures++; $display("FAIL reset_ir: got %h, required 0000", ir); end
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run: got %b, required 0", run); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b, required 0", halted); end
    checks++; if (instr_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d, required 0", instr_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_straight_line();
    int t [3];
    logic [15:0] exp_ir [3];
    exp_ir[0] = 16'h1001; exp_ir[1] = 16'h1002; exp_ir[2] = 16'h1003;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        // the start edge already passed; the first run follows two edges later
        t[k] = -1;
        for (int i = 0; i < 20; i++) begin
          if (run === 1'b1) begin t[k] = cyc; break; end
          tick();
        end
        checks++;
        if (t[k] < 0) begin failures++; $display("FAIL run_timeout: no first run, required one"); end
      end else begin
        wait_run(t[k]);
      end
      checks++;
      if (ir !== exp_ir[k]) begin failures++; $display("FAIL straight_ir%0d: got %h, required %h", k, ir, exp_ir[k]); end
      tick();
      give_done(1'b0, 5'd0);
    end
    checks++; if (t[1] - t[0] != 4) begin failures++; $display("FAIL spacing01: got %0d, required 4", t[1] - t[0]); end
    checks++; if (t[2] - t[1] != 4) begin failures++; $display("FAIL spacing12: got %0d, required 4", t[2] - t[1]); end
    wait_halt();
    checks++; if (addr !== 5'd4) begin failures++; $display("FAIL halt_addr: got %0d, required 4", addr); end
    checks++; if (instr_cnt !== 8'd3) begin failures++; $display("FAIL halt_cnt: got %0d, required 3", instr_cnt); end
    checks++; if (ir !== 16'hFFFF) begin failures++; $display("FAIL halt_ir: got %h, required ffff", ir); end
  endtask

  task automatic test_ignored_in_halt();
    for (int i = 0; i < 3; i++) begin
      done = 1'b1; pc_load = 1'b1; pc_in = 5'd9;
      tick();
    end
    done = 1'b0; pc_load = 1'b0;
    checks++; if (addr !== 5'd4) begin failures++; $display("FAIL halt_ign_addr: got %0d, required 4", addr); end
    checks++; if (instr_cnt !== 8'd3) begin failures++; $display("FAIL halt_ign_cnt: got %0d, required 3", instr_cnt); end
    checks++; if (dbg_state !== S_HALT) begin failures++; $display("FAIL halt_ign_state: got %0d, required %0d", dbg_state, S_HALT); end
  endtask

  task automatic test_redirect();
    int t;
    // restart from HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL restart_addr: got %0d, required 0", addr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL restart_halted: got %b, required 0", halted); end
    wait_run(t); give_done(1'b0, 5'd0);   // 1001
    wait_run(t); give_done(1'b0, 5'd0);   // 1002
    wait_run(t);
    checks++; if (ir !== 16'h1003) begin failures++; $display("FAIL redir_src_ir: got %h, required 1003", ir); end
    give_done(1'b1, 5'd0);
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL redir_addr: got %0d, required 0", addr); end
    checks++; if (instr_cnt !== 8'd6) begin failures++; $display("FAIL redir_cnt: got %0d, required 6", instr_cnt); end
    wait_run(t);
    checks++; if (ir !== 16'h1001) begin failures++; $display("FAIL redir_ir: got %h, required 1001", ir); end
  endtask

  task automatic test_wrap();
    int t;
    give_done(1'b1, 5'd31);
    checks++; if (addr !== 5'd31) begin failures++; $display("FAIL wrap_load: got %0d, required 31", addr); end
    wait_run(t);
    checks++; if (ir !== 16'h2222) begin failures++; $display("FAIL wrap_ir: got %h, required 2222", ir); end
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL wrap_addr: got %0d, required 0", addr); end
    give_done(1'b0, 5'd0);
    wait_run(t);
    checks++; if (ir !== 16'h1001) begin failures++; $display("FAIL wrap_next_ir: got %h, required 1001", ir); end
    checks++; if (instr_cnt !== 8'd8) begin failures++; $display("FAIL wrap_cnt: got %0d, required 8", instr_cnt); end
  endtask

  // entered in a run cycle
  task automatic test_reset_mid();
    bit saw_run;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL mid_run: got %b, required 0", run); end
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL mid_addr: got %0d, required 0", addr); end
    checks++; if (instr_cnt !== 8'd0) begin failures++; $display("FAIL mid_cnt: got %0d, required 0", instr_cnt); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL mid_state: got %0d, required %0d", dbg_state, S_IDLE); end
    saw_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done = 1'b1; pc_load = 1'b1; pc_in = 5'd7;
      tick();
      if (run === 1'b1) saw_run = 1'b1;
    end
    done = 1'b0; pc_load = 1'b0;
    checks++; if (instr_cnt !== 8'd0) begin failures++; $display("FAIL idle_ign_cnt: got %0d, required 0", instr_cnt); end
    checks++; if (addr !== 5'd0) begin failures++; $display("FAIL idle_ign_addr: got %0d, required 0", addr); end
    checks++; if (saw_run !== 1'b0) begin failures++; $display("FAIL idle_ign_run: got %b, required 0", saw_run); end
  endtask

  // Tight loop on word 0, answering done in the run cycle itself.
  task automatic test_saturation();
    int t0, t1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run(t0);
    give_done(1'b1, 5'd0);
    wait_run(t1);
    checks++; if (t1 - t0 != 3) begin failures++; $display("FAIL min_period: got %0d, required 3", t1 - t0); end
    give_done(1'b1, 5'd0);
    for (int i = 2; i < 300; i++) begin
      wait_run(t1);
      if (i == 255) begin
        checks++; if (instr_cnt !== 8'd255) begin failures++; $display("FAIL cnt_at_255: got %0d, required 255", instr_cnt); end
      end
      give_done(1'b1, 5'd0);
    end
    checks++; if (instr_cnt !== 8'd255) begin failures++; $display("FAIL cnt_sat: got %0d, required 255", instr_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h1001;
    mem[1]  = 16'h1002;
    mem[2]  = 16'h1003;
    mem[3]  = 16'hFFFF;
    mem[31] = 16'h2222;

    test_reset();
    test_straight_line();
    test_ignored_in_halt();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the 32-word x 16-bit instruction memory and the simple_processor datapath. It owns the program counter and drives the memory address. It captures each instruction word into an instruction register after the memory read latency, then hands it to the datapath with a run/done handshake. Supports PC redirect on completion, halt detection and a retired-instruction counter.

## Interface
- ADDR_W, 5, width of PC/memory address
- DATA_W, 16, instruction width
- MEM_LAT, 1, memory read latency in cycles (>=1); DIN is valid MEM_LAT cycles after addr changes
- HALT_WORD, 16'hFFFF, instruction word that stops fetching
- clk_addr  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin/restart fetching (level, sampled in IDLE and HALT only)
- DIN  in  DATA_W  instruction memory read data
- done  in  1  datapath finished current instruction
- pc_load  in  1  redirect PC, qualified by done in EXEC
- pc_in  in  ADDR_W  redirect target
- addr  out  ADDR_W  memory address (registered, always equals PC)
- ir  out  DATA_W  instruction register
- run  out  1  one-cycle pulse: ir is valid, datapath may execute
- halted  out  1  high while in HALT
- instr_cnt  out  8  retired-instruction count, saturates at 255

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset -> IDLE with pc=0, ir=0, run=0, halted=0, instr_cnt=0, wait counter=0.
- IDLE: start=1 -> FETCH, wait counter cleared.
- FETCH: lasts MEM_LAT+1 cycles; wait counter increments each cycle. In the final cycle (counter==MEM_LAT): ir<=DIN, pc<=pc+1 mod 2^ADDR_W (31 wraps to 0).
  - DIN==HALT_WORD -> HALT. No run pulse, instr_cnt unchanged.
  - Otherwise -> EXEC, run<=1.
- EXEC: run is high in the first EXEC cycle only. Waits for done=1, accepted in any EXEC cycle, including the run cycle.
  - On done: instr_cnt<=instr_cnt+1 (hold at 255); pc<=pc_in if pc_load=1, else pc unchanged (already incremented); -> FETCH.
- HALT: halted=1, pc and ir held. start=1 -> pc<=0, halted<=0, -> FETCH.
- done and pc_load outside EXEC are ignored. start outside IDLE/HALT is ignored.
- reset in any state, including mid-FETCH or mid-EXEC, returns to IDLE with all reset values on the next edge. A pending run pulse is cancelled.
- Redirect to the address just fetched is legal (tight loop).

## Timing
- addr updates on the same edge as pc; there is no separate address register.
- Edge E samples start=1 in IDLE -> FETCH from E. The final FETCH edge is E+MEM_LAT+1. run=1 and ir valid in the cycle after that edge.
- done accepted at edge D -> next run in the cycle after edge D+MEM_LAT+1. Minimum issue period is MEM_LAT+2 cycles (MEM_LAT=1: 3 cycles).
- instr_cnt and the pc redirect take effect on the same edge that accepts done.
- halted rises in the cycle after the final FETCH edge that saw HALT_WORD.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold reset 2 cycles with done/start toggling -> addr=0, ir=0, run=0, halted=0, instr_cnt=0.
- Straight line: memory words 0..2 = 16'h1001, 16'h1002, 16'h1003, then HALT_WORD at 3. Pulse start, answer each run with done 1 cycle later.
  - Response: run pulses with ir=1001/1002/1003, then halted=1 with addr=4 and instr_cnt=3.
  - Response: run spacing is 4 cycles (3 minimum + 1 done delay).
- Redirect: at the instruction from word 2, assert done with pc_load=1 and pc_in=0 -> next addr=0, ir=16'h1001 re-fetched, instr_cnt increments.
- Wrap: load pc_in=31, word 31 = 16'h2222, word 0 = 16'h1001 -> run with ir=2222, then addr=0, then ir=1001.
- Reset mid-operation: assert reset in the run cycle -> next cycle IDLE, run=0, addr=0, instr_cnt=0. done asserted afterward has no effect.
- Ignored inputs and saturation: done/pc_load pulses in IDLE and HALT leave pc and instr_cnt unchanged. start in HALT restarts from addr 0 with halted cleared. 300 retired instructions -> instr_cnt=255.
